// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: two requester ports and the memory macro side.
// slave  : seen by the arbiter (requests and memory read data in, everything else out).
// master : seen by the environment (requesters and memory model).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              owner;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output owner
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the CPU memory port
// (port 0) and the loader/DMA port (port 1), one transaction in flight at a time.
// Default arbitration: fixed priority to port 0 with a starvation limit (MAX_WAIT)
// guaranteeing port 1 service. Define ARB_ROUND_ROBIN_EN for alternating priority.
// All outputs are registered; reset is asynchronous, active-high.

// Protocol checker: single grant, single response, strobe only with a grant.
module mem_port_arbiter_chk (
    input logic clk,
    input logic reset,
    input logic m0_gnt,
    input logic m1_gnt,
    input logic m0_rvalid,
    input logic m1_rvalid,
    input logic mem_en
);
    a_one_gnt : assert property (@(posedge clk) disable iff (reset) !(m0_gnt && m1_gnt));
    a_one_rvalid : assert property (@(posedge clk) disable iff (reset) !(m0_rvalid && m1_rvalid));
    a_en_with_gnt : assert property (@(posedge clk) disable iff (reset) (mem_en == (m0_gnt || m1_gnt)));
endmodule

module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RSP   = 2'd3
    } state_t;

    // WAIT lasts RD_LAT cycles; the counter is loaded with RD_LAT-1 and runs to zero.
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    state_t            state_q;
    logic [1:0]        lat_cnt_q;
    logic [3:0]        starve_q;
    logic              owner_q;
    logic              m0_gnt_q;
    logic              m1_gnt_q;
    logic              m0_rvalid_q;
    logic              m1_rvalid_q;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

`ifdef ARB_ROUND_ROBIN_EN
    // Port granted last; resets to 1 so port 0 wins the first contested arbitration.
    logic              rr_last_q;
`endif

    logic              any_req_s;
    logic              win_s;
    logic [3:0]        starve_d;

    // Arbitration decision and next starvation count, consumed only in IDLE.
    always_comb begin
        any_req_s = bus.m0_req | bus.m1_req;
        win_s     = 1'b0;
        starve_d  = starve_q;
`ifdef ARB_ROUND_ROBIN_EN
        if (bus.m0_req && bus.m1_req) begin
            win_s = ~rr_last_q;
        end else if (bus.m1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        starve_d = 4'd0;
`else
        if (bus.m0_req && bus.m1_req) begin
            if (starve_q == WAIT_MAX) begin
                win_s    = 1'b1;
                starve_d = 4'd0;
            end else begin
                // starve_q never exceeds WAIT_MAX, so this increment saturates there.
                win_s    = 1'b0;
                starve_d = starve_q + 4'd1;
            end
        end else if (bus.m1_req) begin
            win_s    = 1'b1;
            starve_d = 4'd0;
        end else begin
            // Port 1 not requesting in IDLE: nothing is being starved.
            win_s    = 1'b0;
            starve_d = 4'd0;
        end
`endif
    end

    // Transaction FSM with registered grant, memory strobe and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lat_cnt_q   <= 2'd0;
            starve_q    <= 4'd0;
            owner_q     <= 1'b0;
            m0_gnt_q    <= 1'b0;
            m1_gnt_q    <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= {DATA_W{1'b0}};
            m1_rdata_q  <= {DATA_W{1'b0}};
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_q   <= 1'b1;
`endif
        end else begin
            // Pulses default low; only the states below raise them for one cycle.
            m0_gnt_q    <= 1'b0;
            m1_gnt_q    <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    starve_q <= starve_d;
                    if (any_req_s) begin
                        owner_q     <= win_s;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= win_s ? bus.m1_we    : bus.m0_we;
                        mem_addr_q  <= win_s ? bus.m1_addr  : bus.m0_addr;
                        mem_wdata_q <= win_s ? bus.m1_wdata : bus.m0_wdata;
                        if (win_s) begin
                            m1_gnt_q <= 1'b1;
                        end else begin
                            m0_gnt_q <= 1'b1;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        rr_last_q   <= win_s;
`endif
                        state_q     <= S_ISSUE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (mem_we_q) begin
                        state_q <= S_IDLE;
                    end else begin
                        lat_cnt_q <= LAT_LAST;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt_q == 2'd0) begin
                        // Last WAIT cycle: memory data is valid now; respond next cycle.
                        if (owner_q) begin
                            m1_rdata_q  <= bus.mem_rdata;
                            m1_rvalid_q <= 1'b1;
                        end else begin
                            m0_rdata_q  <= bus.mem_rdata;
                            m0_rvalid_q <= 1'b1;
                        end
                        state_q <= S_RSP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 2'd1;
                        state_q   <= S_WAIT;
                    end
                end
                S_RSP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.m0_gnt    = m0_gnt_q;
    assign bus.m1_gnt    = m1_gnt_q;
    assign bus.m0_rvalid = m0_rvalid_q;
    assign bus.m1_rvalid = m1_rvalid_q;
    assign bus.m0_rdata  = m0_rdata_q;
    assign bus.m1_rdata  = m1_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.owner     = owner_q;

    mem_port_arbiter_chk u_chk (
        .clk       (clk),
        .reset     (reset),
        .m0_gnt    (m0_gnt_q),
        .m1_gnt    (m1_gnt_q),
        .m0_rvalid (m0_rvalid_q),
        .m1_rvalid (m1_rvalid_q),
        .mem_en    (mem_en_q)
    );
endmodule
